// File: rtl/rr_mux_arb.sv
// N:1 registered multiplexer with per-channel valid/ready handshake and a
// round-robin / fixed-priority arbiter; the output register also records the source index.
module rr_mux_arb #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 8,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    logic [SW-1:0] rr_ptr_q, rr_ptr_d;
    logic          valid_q, valid_d;
    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] sel_q, sel_d;

    logic [N-1:0]  grant;
    logic [SW-1:0] grant_idx;
    logic          grant_any;
    logic [SW:0]   sum;
    logic [SW-1:0] cand;
    logic          load_en;
    logic          in_xfer;
    logic [W-1:0]  ch_data [N];

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            ch_data[i] = in_data[i*W +: W];
        end
    end

    // Candidate k is rr_ptr+k mod N in round-robin mode, plain k in fixed-priority mode.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr_q} + (SW+1)'(k);
            if (sum >= (SW+1)'(N)) begin
                sum = sum - (SW+1)'(N);
            end
            cand = mode ? SW'(k) : sum[SW-1:0];
            if (!grant_any && in_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign load_en  = !valid_q || out_ready;
    assign in_xfer  = grant_any && load_en;
    // Reset gates in_ready so producers never see an accept while the block is held.
    assign in_ready = (rst_n && load_en) ? grant : '0;

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        if (in_xfer) begin
            valid_d = 1'b1;
            data_d  = ch_data[grant_idx];
            sel_d   = grant_idx;
            if (!mode) begin
                rr_ptr_d = (grant_idx == SW'(N-1)) ? '0 : grant_idx + SW'(1);
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: a 4-channel and a 3-channel instance sharing clock and reset.
module tb_rr_mux_arb;

    logic        clk;
    logic        rst_n;

    logic        mode4, ordy4, ov4;
    logic [3:0]  v4, rdy4;
    logic [31:0] d4;
    logic [7:0]  od4;
    logic [1:0]  os4;

    logic        mode3, ordy3, ov3;
    logic [2:0]  v3, rdy3;
    logic [23:0] d3;
    logic [7:0]  od3;
    logic [1:0]  os3;

    int n_cmp = 0;
    int n_err = 0;

    rr_mux_arb #(.N(4), .W(8)) u4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode4),
        .in_valid  (v4),
        .in_data   (d4),
        .in_ready  (rdy4),
        .out_valid (ov4),
        .out_data  (od4),
        .out_sel   (os4),
        .out_ready (ordy4)
    );

    rr_mux_arb #(.N(3), .W(8)) u3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode3),
        .in_valid  (v3),
        .in_data   (d3),
        .in_ready  (rdy3),
        .out_valid (ov3),
        .out_data  (od3),
        .out_sel   (os3),
        .out_ready (ordy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        mode4 = 1'b0; ordy4 = 1'b1; v4 = 4'b0100; d4 = 32'h00A5_0000;
        mode3 = 1'b0; ordy3 = 1'b1; v3 = 3'b000;  d3 = 24'h22_2120;
        #3;
        chk("rst_ready", rdy4, 4'b0000);
        chk("rst_valid", ov4, 1'b0);
        chk("rst_data", od4, 8'h00);
        chk("rst_sel", os4, 2'd0);

        // Single channel
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("single_ready", rdy4, 4'b0100);
        tick();
        chk("single_valid", ov4, 1'b1);
        chk("single_data", od4, 8'hA5);
        chk("single_sel", os4, 2'd2);
        v4 = 4'b0000;
        #1;
        chk("idle_ready", rdy4, 4'b0000);
        tick();
        chk("drain_valid", ov4, 1'b0);
        chk("drain_hold_data", od4, 8'hA5);
        chk("drain_hold_sel", os4, 2'd2);

        // rr_ptr is 3: of channels 0 and 3, channel 3 wins
        d4 = 32'h1312_1110;
        v4 = 4'b1001;
        #1;
        chk("ptr3_ready", rdy4, 4'b1000);
        tick();
        chk("ptr3_sel", os4, 2'd3);
        chk("ptr3_data", od4, 8'h13);

        // Fairness: rr_ptr wrapped to 0
        v4 = 4'b1111;
        #1;
        chk("rr_first_ready", rdy4, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_sel", os4, 32'(i % 4));
            chk("rr_data", od4, 32'(8'h10 + i % 4));
            chk("rr_valid", ov4, 1'b1);
        end
        tick();
        chk("rr_extra_sel", os4, 2'd0);

        // Fixed priority; rr_ptr is 1 and must stay 1
        mode4 = 1'b1;
        v4 = 4'b1101;
        #1;
        chk("fix_comb_ready", rdy4, 4'b0001);
        v4 = 4'b1110;
        #1;
        chk("fix_ready", rdy4, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fix_sel", os4, 2'd1);
            chk("fix_data", od4, 8'h11);
        end
        v4 = 4'b1100;
        #1;
        chk("fix2_ready", rdy4, 4'b0100);
        tick();
        chk("fix2_sel", os4, 2'd2);
        mode4 = 1'b0;
        v4 = 4'b1111;
        #1;
        chk("ptr_retained", rdy4, 4'b0010);

        // Backpressure
        tick();
        chk("bp_load_data", od4, 8'h11);
        ordy4 = 1'b0;
        #1;
        chk("bp_ready", rdy4, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", ov4, 1'b1);
            chk("bp_hold_data", od4, 8'h11);
            chk("bp_hold_sel", os4, 2'd1);
            chk("bp_hold_ready", rdy4, 4'b0000);
        end
        ordy4 = 1'b1;
        #1;
        chk("bp_release_ready", rdy4, 4'b0100);
        tick();
        chk("nobubble_valid", ov4, 1'b1);
        chk("nobubble_data", od4, 8'h12);
        chk("nobubble_sel", os4, 2'd2);

        // Mid-cycle async reset with a word pending; rr_ptr is 3 before it
        v4 = 4'b0100;
        tick();
        chk("pre_rst_valid", ov4, 1'b1);
        v4 = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ov4, 1'b0);
        chk("mid_rst_data", od4, 8'h00);
        chk("mid_rst_sel", os4, 2'd0);
        chk("mid_rst_ready", rdy4, 4'b0000);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", rdy4, 4'b0001);
        v4 = 4'b0000;

        // N=3 wrap
        v3 = 3'b010;
        #1;
        chk("n3_first_ready", rdy3, 3'b010);
        tick();
        chk("n3_first_sel", os3, 2'd1);
        v3 = 3'b011;
        #1;
        chk("n3_wrap_ready", rdy3, 3'b001);
        tick();
        chk("n3_wrap_sel", os3, 2'd0);
        chk("n3_wrap_data", od3, 8'h20);
        #1;
        chk("n3_next_ready", rdy3, 3'b010);
        tick();
        chk("n3_next_sel", os3, 2'd1);
        v3 = 3'b100;
        tick();
        chk("n3_top_sel", os3, 2'd2);
        chk("n3_top_data", od3, 8'h22);
        v3 = 3'b111;
        #1;
        chk("n3_top_wrap_ready", rdy3, 3'b001);
        v3 = 3'b000;
        tick();
        chk("n3_drain_valid", ov3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
